// File: rtl/block_lock_66b_pkg.sv
// Shared definitions for the 64b/66b block-lock stage: sync header codes
// and the lock state encoding.
package block_lock_66b_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_SLIP     = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_t;

endpackage

// File: rtl/block_lock_66b.sv
// 64b/66b block synchroniser: checks sync headers from the gearbox, commands
// bit-slips until block lock is acquired, and forwards registered beats with
// a lock-qualified valid toward the descrambler.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   data_in         scrambled payload from gearbox
//   hdr_in          2-bit sync header from gearbox
//   data_in_valid   beat qualifier for data_in/hdr_in
//   bitslip         one-cycle pulse asking the gearbox to shift by one bit
//   data_out        registered data_in (loads on valid beats)
//   hdr_out         registered hdr_in (loads on valid beats)
//   data_out_valid  registered data_in_valid qualified by LOCKED
//   block_lock      high while in LOCKED
module block_lock_66b
  import block_lock_66b_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned VALID_COUNT     = 64,
  parameter int unsigned INVALID_COUNT   = 16,
  parameter int unsigned BITSLIP_HOLDOFF = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            hdr_in,
  input  logic                  data_in_valid,
  output logic                  bitslip,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            hdr_out,
  output logic                  data_out_valid,
  output logic                  block_lock
);

  localparam int unsigned SH_CNT_W = $clog2(VALID_COUNT + 1);
  localparam int unsigned INVLD_W  = $clog2(INVALID_COUNT + 1);
  localparam int unsigned HOLD_W   = $clog2(BITSLIP_HOLDOFF + 1);

  localparam logic [SH_CNT_W-1:0] SH_LAST    = SH_CNT_W'(VALID_COUNT - 1);
  localparam logic [INVLD_W-1:0]  INVLD_LAST = INVLD_W'(INVALID_COUNT - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LOAD  = HOLD_W'(BITSLIP_HOLDOFF);
  localparam logic [HOLD_W-1:0]   HOLD_ONE   = HOLD_W'(1);

  lock_state_t          state;
  logic [SH_CNT_W-1:0]  sh_cnt;
  logic [INVLD_W-1:0]   sh_invld_cnt;
  logic [HOLD_W-1:0]    holdoff;
  logic                 hdr_ok;

  // Only 01 and 10 are legal sync headers.
  assign hdr_ok = (hdr_in == SYNC_DATA) || (hdr_in == SYNC_CTRL);

  // Datapath register and lock FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_UNLOCKED;
      sh_cnt         <= '0;
      sh_invld_cnt   <= '0;
      holdoff        <= '0;
      bitslip        <= 1'b0;
      block_lock     <= 1'b0;
      data_out       <= '0;
      hdr_out        <= '0;
      data_out_valid <= 1'b0;
    end else begin
      bitslip        <= 1'b0;
      data_out_valid <= data_in_valid && (state == ST_LOCKED);
      if (data_in_valid) begin
        data_out <= data_in;
        hdr_out  <= hdr_in;
      end

      case (state)
        ST_UNLOCKED: begin
          if (data_in_valid) begin
            if (!hdr_ok) begin
              state        <= ST_SLIP;
              bitslip      <= 1'b1;
              sh_cnt       <= '0;
              sh_invld_cnt <= '0;
              holdoff      <= HOLD_LOAD;
            end else if (sh_cnt == SH_LAST) begin
              state        <= ST_LOCKED;
              block_lock   <= 1'b1;
              sh_cnt       <= '0;
              sh_invld_cnt <= '0;
            end else begin
              sh_cnt <= sh_cnt + 1'b1;
            end
          end
        end

        // Gearbox settles; input beats are ignored, holdoff counts clk cycles.
        ST_SLIP: begin
          block_lock <= 1'b0;
          if (holdoff <= HOLD_ONE) begin
            state   <= ST_UNLOCKED;
            holdoff <= '0;
          end else begin
            holdoff <= holdoff - 1'b1;
          end
        end

        ST_LOCKED: begin
          if (data_in_valid) begin
            // Loss of lock takes priority over a coincident window end.
            if (!hdr_ok && (sh_invld_cnt == INVLD_LAST)) begin
              state        <= ST_SLIP;
              block_lock   <= 1'b0;
              bitslip      <= 1'b1;
              sh_cnt       <= '0;
              sh_invld_cnt <= '0;
              holdoff      <= HOLD_LOAD;
            end else if (sh_cnt == SH_LAST) begin
              sh_cnt       <= '0;
              sh_invld_cnt <= '0;
            end else begin
              sh_cnt <= sh_cnt + 1'b1;
              if (!hdr_ok) begin
                sh_invld_cnt <= sh_invld_cnt + 1'b1;
              end
            end
          end
        end

        default: begin
          state      <= ST_UNLOCKED;
          block_lock <= 1'b0;
        end
      endcase
    end
  end

endmodule
